// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU pipeline types, opcodes and default widths
package cpu_pkg;

    localparam int DefDataW = 16;
    localparam int DefAddrW = 16;

    localparam logic [4:0] Load    = 5'b01010;
    localparam logic [4:0] Store   = 5'b01011;
    localparam logic [4:0] DbLoad  = 5'b01100;
    localparam logic [4:0] DbStore = 5'b01101;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_RD   = 2'd1,
        BUS_WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/bus_master.sv
// rtl/bus_master.sv - data-bus request/ack handshake with timeout and sticky error
module bus_master
    import cpu_pkg::*;
#(
    parameter int DATA_W      = DefDataW,
    parameter int ADDR_W      = DefAddrW,
    parameter int BUS_TIMEOUT = 255
) (
    input  logic              iclk,
    input  logic              irst_n,
    input  logic              start,
    input  logic              startWe,
    input  logic [ADDR_W-1:0] startAddr,
    input  logic [DATA_W-1:0] startWrData,
    output logic              oBusReq,
    output logic              oBusWe,
    output logic [ADDR_W-1:0] oBusAddr,
    output logic [DATA_W-1:0] oBusWrData,
    input  logic              iBusAck,
    input  logic [DATA_W-1:0] iBusRdData,
    output logic              done,
    output logic              timeout,
    output logic [DATA_W-1:0] rdData,
    output logic              oBusErr
);

    localparam int CntW = $clog2(BUS_TIMEOUT + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(BUS_TIMEOUT - 1);

    logic [CntW-1:0] waitCnt;

    // Ack is only meaningful while a request is outstanding; an ack on the last cycle wins over timeout.
    assign done    = oBusReq & iBusAck;
    assign timeout = oBusReq & ~iBusAck & (waitCnt == LastCnt);
    assign rdData  = iBusRdData;

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            oBusReq    <= 1'b0;
            oBusWe     <= 1'b0;
            oBusAddr   <= '0;
            oBusWrData <= '0;
            oBusErr    <= 1'b0;
            waitCnt    <= '0;
        end else if (start) begin
            oBusReq    <= 1'b1;
            oBusWe     <= startWe;
            oBusAddr   <= startAddr;
            oBusWrData <= startWrData;
            waitCnt    <= '0;
        end else if (done || timeout) begin
            oBusReq <= 1'b0;
            waitCnt <= '0;
            if (timeout) begin
                oBusErr <= 1'b1;
            end
        end else if (oBusReq) begin
            waitCnt <= waitCnt + 1'b1;
        end
    end

endmodule

// File: rtl/memwb_stage.sv
// rtl/memwb_stage.sv - memory/writeback stage: RAM load/store, data-bus ops, register writeback
module memwb_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W      = DefDataW,
    parameter int ADDR_W      = DefAddrW,
    parameter int BUS_TIMEOUT = 255
) (
    input  logic              iclk,
    input  logic              irst_n,
    input  logic              iValid,
    input  logic              iWriteReg,
    input  logic [3:0]        iWriteRegAddr,
    input  logic              iMemRead,
    input  logic              iMemWrite,
    input  logic              iBustoReg,
    input  logic              iBusWrite,
    input  logic [DATA_W-1:0] iALUResult,
    input  logic [DATA_W-1:0] iStoreData,
    output logic [ADDR_W-1:0] oMemAddr,
    output logic [DATA_W-1:0] oMemWrData,
    output logic              oMemWe,
    output logic              oMemRe,
    input  logic [DATA_W-1:0] iMemRdData,
    output logic              oBusReq,
    output logic              oBusWe,
    output logic [ADDR_W-1:0] oBusAddr,
    output logic [DATA_W-1:0] oBusWrData,
    input  logic              iBusAck,
    input  logic [DATA_W-1:0] iBusRdData,
    output logic              oWriteReg,
    output logic              oMemtoReg,
    output logic              oBustoReg,
    output logic [3:0]        oWriteRegAddr,
    output logic [DATA_W-1:0] oWriteRegData,
    output logic              oStall,
    output logic              oBusErr
);

    state_t state, nextState;

    logic              busOp, isBus, isLoad, isStore, isAlu, wrEn;
    logic              busStart, busDone, busTimeout;
    logic [DATA_W-1:0] busRdData;
    logic [3:0]        pendAddr;
    logic              pendRead;

    // Decode priority for illegal multi-bit combinations: bus > load > store > ALU.
    assign busOp   = iBustoReg | iBusWrite;
    assign isBus   = iValid & busOp;
    assign isLoad  = iValid & ~busOp & iMemRead;
    assign isStore = iValid & ~busOp & ~iMemRead & iMemWrite;
    assign isAlu   = iValid & ~busOp & ~iMemRead & ~iMemWrite;
    assign wrEn    = iWriteReg & ~(iMemWrite | iBusWrite);

    assign oMemAddr   = iALUResult[ADDR_W-1:0];
    assign oMemWrData = iStoreData;
    assign oStall     = (state != IDLE) | (iValid & (iMemRead | iBustoReg | iBusWrite));

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        oMemWe    = 1'b0;
        oMemRe    = 1'b0;
        busStart  = 1'b0;
        case (state)
            IDLE: begin
                if (isBus) begin
                    busStart  = 1'b1;
                    nextState = BUS_WAIT;
                end else if (isLoad) begin
                    oMemRe    = 1'b1;
                    nextState = MEM_RD;
                end else if (isStore) begin
                    oMemWe = 1'b1;
                end
            end
            MEM_RD:   nextState = IDLE;
            BUS_WAIT: begin
                if (busDone || busTimeout) begin
                    nextState = IDLE;
                end
            end
            default:  nextState = IDLE;
        endcase
    end

    // Strobes are single-cycle pulses; address and data hold their last written value.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            oWriteReg     <= 1'b0;
            oMemtoReg     <= 1'b0;
            oBustoReg     <= 1'b0;
            oWriteRegAddr <= '0;
            oWriteRegData <= '0;
            pendAddr      <= '0;
            pendRead      <= 1'b0;
        end else begin
            oWriteReg <= 1'b0;
            oMemtoReg <= 1'b0;
            oBustoReg <= 1'b0;
            case (state)
                IDLE: begin
                    if (isBus) begin
                        pendAddr <= iWriteRegAddr;
                        pendRead <= ~iBusWrite;
                    end else if (isLoad) begin
                        pendAddr <= iWriteRegAddr;
                    end else if (isAlu && wrEn) begin
                        oWriteReg     <= 1'b1;
                        oWriteRegAddr <= iWriteRegAddr;
                        oWriteRegData <= iALUResult;
                    end
                end
                MEM_RD: begin
                    oMemtoReg     <= 1'b1;
                    oWriteRegAddr <= pendAddr;
                    oWriteRegData <= iMemRdData;
                end
                BUS_WAIT: begin
                    if (busDone && pendRead) begin
                        oBustoReg     <= 1'b1;
                        oWriteRegAddr <= pendAddr;
                        oWriteRegData <= busRdData;
                    end
                end
                default: ;
            endcase
        end
    end

    bus_master #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .BUS_TIMEOUT (BUS_TIMEOUT)
    ) uBusMaster (
        .iclk        (iclk),
        .irst_n      (irst_n),
        .start       (busStart),
        .startWe     (iBusWrite),
        .startAddr   (iALUResult[ADDR_W-1:0]),
        .startWrData (iStoreData),
        .oBusReq     (oBusReq),
        .oBusWe      (oBusWe),
        .oBusAddr    (oBusAddr),
        .oBusWrData  (oBusWrData),
        .iBusAck     (iBusAck),
        .iBusRdData  (iBusRdData),
        .done        (busDone),
        .timeout     (busTimeout),
        .rdData      (busRdData),
        .oBusErr     (oBusErr)
    );

endmodule

// File: tb/tb_memwb_stage.sv
// tb/tb_memwb_stage.sv - self-checking bench for memwb_stage with RAM, bus responder and reference model
module tb_memwb_stage;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int TO = 8;

    logic          iclk, irst_n, iValid, iWriteReg, iMemRead, iMemWrite, iBustoReg, iBusWrite;
    logic [3:0]    iWriteRegAddr;
    logic [DW-1:0] iALUResult, iStoreData, iMemRdData, iBusRdData;
    logic [AW-1:0] oMemAddr, oBusAddr;
    logic [DW-1:0] oMemWrData, oBusWrData, oWriteRegData;
    logic          oMemWe, oMemRe, oBusReq, oBusWe, iBusAck;
    logic          oWriteReg, oMemtoReg, oBustoReg, oStall, oBusErr;
    logic [3:0]    oWriteRegAddr;

    int vectors = 0;
    int miscompares = 0;

    memwb_stage #(.DATA_W(DW), .ADDR_W(AW), .BUS_TIMEOUT(TO)) dut (
        .iclk(iclk), .irst_n(irst_n), .iValid(iValid), .iWriteReg(iWriteReg),
        .iWriteRegAddr(iWriteRegAddr), .iMemRead(iMemRead), .iMemWrite(iMemWrite),
        .iBustoReg(iBustoReg), .iBusWrite(iBusWrite), .iALUResult(iALUResult),
        .iStoreData(iStoreData), .oMemAddr(oMemAddr), .oMemWrData(oMemWrData),
        .oMemWe(oMemWe), .oMemRe(oMemRe), .iMemRdData(iMemRdData), .oBusReq(oBusReq),
        .oBusWe(oBusWe), .oBusAddr(oBusAddr), .oBusWrData(oBusWrData), .iBusAck(iBusAck),
        .iBusRdData(iBusRdData), .oWriteReg(oWriteReg), .oMemtoReg(oMemtoReg),
        .oBustoReg(oBustoReg), .oWriteRegAddr(oWriteRegAddr), .oWriteRegData(oWriteRegData),
        .oStall(oStall), .oBusErr(oBusErr)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    // Environment RAM: 16 words indexed by the low address nibble, 1-cycle read latency.
    logic [DW-1:0] ram [0:15];
    always @(posedge iclk) begin
        if (!irst_n) begin
            for (int i = 0; i < 16; i++) ram[i] <= 16'(i * 16'h0111) ^ 16'h5A5A;
        end else begin
            if (oMemWe) ram[oMemAddr[3:0]] <= oMemWrData;
            if (oMemRe) iMemRdData <= ram[oMemAddr[3:0]];
        end
    end

    // Bus responder: acks during the ackDelay-th cycle of an outstanding request.
    int            ackDelay = 1000;
    logic [DW-1:0] ackData  = '0;
    logic          strayAck = 1'b0;
    int            reqCnt   = 0;
    initial begin
        iBusAck    = 1'b0;
        iBusRdData = '0;
        forever begin
            @(posedge iclk);
            #1;
            if (oBusReq) reqCnt++;
            else reqCnt = 0;
            iBusAck    = (oBusReq && reqCnt == ackDelay) || strayAck;
            iBusRdData = ackData;
        end
    end

    // Reference model state.
    logic [DW-1:0] refMem [0:15];
    logic          refErr;

    task automatic modelReset();
        for (int i = 0; i < 16; i++) refMem[i] = 16'(i * 16'h0111) ^ 16'h5A5A;
        refErr = 1'b0;
    endtask

    task automatic clearInputs();
        iValid = 0; iWriteReg = 0; iMemRead = 0; iMemWrite = 0; iBustoReg = 0; iBusWrite = 0;
    endtask

    task automatic doOp(input logic mRd, input logic mWr, input logic bRd, input logic bWr,
                        input logic wr, input logic [3:0] rd, input logic [15:0] a,
                        input logic [15:0] sd, input int d, input logic [15:0] ad);
        int kind, expN, expK, expReq, gotN, gotK, reqN, nS;
        logic [2:0] expType, gotType;
        logic [3:0] expAddr, gotAddr;
        logic [15:0] expData, gotData;
        logic busFieldsSeen;
        expN = 0; expK = 0; expReq = 0; expType = 0; expAddr = rd; expData = 0;
        if (bRd || bWr) begin
            kind = 3;
            expReq = (d <= TO) ? d : TO;
            if (d <= TO) begin
                if (!bWr) begin expN = 1; expK = d + 1; expType = 3'b100; expData = ad; end
            end else begin
                refErr = 1'b1;
            end
        end else if (mRd) begin
            kind = 2; expN = 1; expK = 2; expType = 3'b010; expData = refMem[a[3:0]];
        end else if (mWr) begin
            kind = 1; refMem[a[3:0]] = sd;
        end else begin
            kind = 0;
            if (wr) begin expN = 1; expK = 1; expType = 3'b001; expData = a; end
        end

        @(posedge iclk); #1;
        iValid = 1; iMemRead = mRd; iMemWrite = mWr; iBustoReg = bRd; iBusWrite = bWr;
        iWriteReg = wr; iWriteRegAddr = rd; iALUResult = a; iStoreData = sd;
        ackDelay = d; ackData = ad;
        @(negedge iclk);
        vectors++;
        if ({oStall, oMemWe, oMemRe} !== {kind >= 2, kind == 1, kind == 2}) begin
            miscompares++;
            $display("FAIL accept_ctrl: {stall,we,re} got %b expected %b", {oStall, oMemWe, oMemRe},
                     {kind >= 2, kind == 1, kind == 2});
        end
        if (kind == 1) begin
            vectors++;
            if ({oMemAddr, oMemWrData} !== {a, sd}) begin
                miscompares++;
                $display("FAIL store_bus: got %h/%h expected %h/%h", oMemAddr, oMemWrData, a, sd);
            end
        end
        @(posedge iclk); #1;
        clearInputs();
        gotN = 0; gotK = 0; reqN = 0; gotType = 0; gotAddr = 0; gotData = 0; busFieldsSeen = 0;
        for (int k = 1; k <= TO + 3; k++) begin
            if (oBusReq) begin
                reqN++;
                if (k == 1) busFieldsSeen = 1;
                if (k == 1 && {oBusWe, oBusAddr, oBusWrData} !== {bWr, a, sd}) begin
                    miscompares++;
                    $display("FAIL bus_fields: got %b/%h/%h expected %b/%h/%h",
                             oBusWe, oBusAddr, oBusWrData, bWr, a, sd);
                end
            end
            nS = int'(oWriteReg) + int'(oMemtoReg) + int'(oBustoReg);
            if (nS != 0) begin
                gotN += nS; gotK = k; gotType = {oBustoReg, oMemtoReg, oWriteReg};
                gotAddr = oWriteRegAddr; gotData = oWriteRegData;
            end
            @(posedge iclk); #1;
        end
        if (busFieldsSeen) vectors++;
        vectors++;
        if (gotN != expN) begin
            miscompares++;
            $display("FAIL wb_count: got %0d expected %0d", gotN, expN);
        end
        if (expN == 1 && gotN == 1) begin
            vectors++;
            if (gotK != expK || gotType !== expType || gotAddr !== expAddr || gotData !== expData) begin
                miscompares++;
                $display("FAIL wb_event: got k%0d t%b r%h d%h expected k%0d t%b r%h d%h",
                         gotK, gotType, gotAddr, gotData, expK, expType, expAddr, expData);
            end
        end
        vectors++;
        if (reqN != expReq) begin
            miscompares++;
            $display("FAIL bus_req_cycles: got %0d expected %0d", reqN, expReq);
        end
        vectors++;
        if (oBusErr !== refErr || oStall !== 1'b0) begin
            miscompares++;
            $display("FAIL end_state: err/stall got %b/%b expected %b/0", oBusErr, oStall, refErr);
        end
    endtask

    task automatic test_reset();
        irst_n = 0; clearInputs(); iWriteRegAddr = 0; iALUResult = 0; iStoreData = 0;
        modelReset();
        repeat (2) @(posedge iclk);
        @(negedge iclk);
        vectors++;
        if ({oBusReq, oBusWe, oBusAddr, oBusWrData, oWriteReg, oMemtoReg, oBustoReg,
             oWriteRegAddr, oWriteRegData, oBusErr, oStall} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: req%b we%b a%h d%h wb%b%b%b r%h wd%h err%b stall%b expected all 0",
                     oBusReq, oBusWe, oBusAddr, oBusWrData, oWriteReg, oMemtoReg, oBustoReg,
                     oWriteRegAddr, oWriteRegData, oBusErr, oStall);
        end
        irst_n = 1;
    endtask

    task automatic test_alu();
        doOp(0, 0, 0, 0, 1, 4'h3, 16'h1234, 16'h0000, 1000, 16'h0);
        doOp(0, 0, 0, 0, 0, 4'h4, 16'h4321, 16'h0000, 1000, 16'h0);
    endtask

    task automatic test_store_load();
        doOp(0, 1, 0, 0, 0, 4'h0, 16'h0040, 16'hBEEF, 1000, 16'h0);
        doOp(1, 0, 0, 0, 0, 4'h5, 16'h0040, 16'h0000, 1000, 16'h0);
    endtask

    task automatic test_dbload();
        doOp(0, 0, 1, 0, 0, 4'h7, 16'h8000, 16'h1111, 3, 16'h00A5);
    endtask

    task automatic test_ack_on_timeout();
        doOp(0, 0, 1, 0, 0, 4'hA, 16'h8002, 16'h0000, TO, 16'h5A5A);
    endtask

    task automatic test_timeout();
        doOp(0, 0, 0, 1, 1, 4'h2, 16'h9000, 16'hCAFE, 1000, 16'h0);
        doOp(0, 0, 0, 0, 1, 4'h8, 16'h0ACE, 16'h0000, 1000, 16'h0);
    endtask

    task automatic test_back_to_back();
        logic [15:0] ld;
        ld = refMem[2];
        @(posedge iclk); #1;
        iValid = 1; iWriteReg = 1; iWriteRegAddr = 4'h1; iALUResult = 16'hAAAA;
        @(posedge iclk); #1;
        vectors++;
        if ({oWriteReg, oWriteRegAddr, oWriteRegData} !== {1'b1, 4'h1, 16'hAAAA}) begin
            miscompares++;
            $display("FAIL b2b_alu1: got %b/%h/%h expected 1/1/aaaa", oWriteReg, oWriteRegAddr, oWriteRegData);
        end
        iWriteRegAddr = 4'h2; iALUResult = 16'h5555;
        @(posedge iclk); #1;
        vectors++;
        if ({oWriteReg, oWriteRegAddr, oWriteRegData} !== {1'b1, 4'h2, 16'h5555}) begin
            miscompares++;
            $display("FAIL b2b_alu2: got %b/%h/%h expected 1/2/5555", oWriteReg, oWriteRegAddr, oWriteRegData);
        end
        clearInputs();
        iValid = 1; iMemRead = 1; iWriteRegAddr = 4'h4; iALUResult = 16'h0002;
        @(posedge iclk); #1;
        iMemRead = 0; iWriteReg = 1; iWriteRegAddr = 4'h6; iALUResult = 16'h0F0F;
        @(negedge iclk);
        vectors++;
        if (oStall !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_load_stall: got %b expected 1", oStall);
        end
        @(posedge iclk); #1;
        vectors++;
        if ({oMemtoReg, oWriteReg, oWriteRegAddr, oWriteRegData} !== {2'b10, 4'h4, ld}) begin
            miscompares++;
            $display("FAIL b2b_load_wb: got %b%b/%h/%h expected 10/4/%h",
                     oMemtoReg, oWriteReg, oWriteRegAddr, oWriteRegData, ld);
        end
        @(negedge iclk);
        vectors++;
        if (oStall !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_idle_stall: got %b expected 0", oStall);
        end
        @(posedge iclk); #1;
        clearInputs();
        vectors++;
        if ({oWriteReg, oWriteRegAddr, oWriteRegData} !== {1'b1, 4'h6, 16'h0F0F}) begin
            miscompares++;
            $display("FAIL b2b_alu_after_load: got %b/%h/%h expected 1/6/0f0f",
                     oWriteReg, oWriteRegAddr, oWriteRegData);
        end
        @(posedge iclk); #1;
        vectors++;
        if ({oWriteReg, oMemtoReg, oBustoReg} !== 3'b000) begin
            miscompares++;
            $display("FAIL b2b_no_extra_wb: got %b expected 000", {oWriteReg, oMemtoReg, oBustoReg});
        end
    endtask

    task automatic test_reset_midwait();
        logic seen;
        @(posedge iclk); #1;
        ackDelay = 1000;
        iValid = 1; iBustoReg = 1; iWriteRegAddr = 4'h9; iALUResult = 16'h1234;
        @(posedge iclk); #1;
        clearInputs();
        @(posedge iclk);
        @(negedge iclk);
        vectors++;
        if (oBusReq !== 1'b1) begin
            miscompares++;
            $display("FAIL midwait_req: got %b expected 1", oBusReq);
        end
        #2 irst_n = 0;
        #1;
        vectors++;
        if ({oBusReq, oBusWe, oBusAddr, oBusWrData, oWriteReg, oMemtoReg, oBustoReg,
             oWriteRegAddr, oWriteRegData, oBusErr, oStall} !== '0) begin
            miscompares++;
            $display("FAIL async_reset: req%b wb%b%b%b err%b stall%b expected all 0",
                     oBusReq, oWriteReg, oMemtoReg, oBustoReg, oBusErr, oStall);
        end
        modelReset();
        @(negedge iclk);
        irst_n = 1;
        strayAck = 1;
        @(negedge iclk);
        strayAck = 0;
        seen = 0;
        repeat (4) begin
            @(negedge iclk);
            if (oWriteReg || oMemtoReg || oBustoReg || oBusReq || oStall) seen = 1;
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL stray_ack: activity got %b expected 0", seen);
        end
    endtask

    task automatic test_random();
        logic [4:0] bits;
        for (int n = 0; n < 250; n++) begin
            bits = 5'b00001 << $urandom_range(0, 4);
            if ($urandom_range(0, 7) == 0) bits = bits | (5'b00001 << $urandom_range(0, 4));
            doOp(bits[1], bits[2], bits[3], bits[4], 1'($urandom), 4'($urandom), 16'($urandom),
                 16'($urandom), $urandom_range(1, TO + 2), 16'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_store_load();
        test_dbload();
        test_ack_on_timeout();
        test_timeout();
        test_back_to_back();
        test_reset_midwait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
